// File: rtl/music_player.sv
// rtl/music_player.sv - beat-sequenced square-wave tone generator driven by an external song table
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst       in   1   synchronous active-high reset
//   start     in   1   pulse: play from beat 0 (restarts if already playing)
//   stop      in   1   pulse: end playback (wins over start)
//   loop_en   in   1   wrap from LAST_BEAT to 0 instead of ending
//   tone      in   32  note frequency in Hz for ibeatNum (combinational table)
//   ibeatNum  out  9   current beat index
//   audio     out  1   square-wave output
//   busy      out  1   high while playing
//   song_done out  1   one-cycle pulse when a non-looping song ends
module music_player #(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned BEATS_PER_SEC = 8,
  parameter int unsigned LAST_BEAT     = 255,
  parameter int unsigned SILENCE_HZ    = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic [31:0] tone,
  output logic [8:0]  ibeatNum,
  output logic        audio,
  output logic        busy,
  output logic        song_done
);

  localparam int unsigned BEAT_CYC      = CLK_HZ / BEATS_PER_SEC;
  localparam logic [31:0] BEAT_LAST     = 32'(BEAT_CYC - 1);
  localparam logic [8:0]  LAST_BEAT_IDX = 9'(LAST_BEAT);
  localparam logic [32:0] DIVIDEND      = 33'(CLK_HZ);
  localparam logic [31:0] SILENCE       = 32'(SILENCE_HZ);

  typedef enum logic {S_IDLE, S_PLAY} state_e;

  state_e      state_q, state_d;
  logic [8:0]  beat_q, beat_d;
  logic [31:0] timer_q, timer_d;
  logic        load_q, load_d;        // tone sample due this cycle
  logic [31:0] tone_q, tone_d;
  logic        div_run_q, div_run_d;
  logic [5:0]  div_cnt_q, div_cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;          // dividend bits shift out, quotient bits shift in
  logic        div_done_q, div_done_d;
  logic [31:0] half_q, half_d;        // 0 means silent
  logic [31:0] sq_cnt_q, sq_cnt_d;
  logic        audio_q, audio_d;
  logic        done_q, done_d;

  logic [33:0] rem_shift;
  logic [33:0] divisor;
  logic        rest_tone;

  always_comb begin
    rem_shift  = {rem_q, quo_q[31]};
    divisor    = {1'b0, tone_q, 1'b0};
    rest_tone  = (tone == 32'd0) || (tone >= SILENCE);

    state_d    = state_q;
    beat_d     = beat_q;
    timer_d    = timer_q;
    load_d     = 1'b0;
    tone_d     = tone_q;
    div_run_d  = div_run_q;
    div_cnt_d  = div_cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    div_done_d = 1'b0;
    half_d     = half_q;
    sq_cnt_d   = sq_cnt_q;
    audio_d    = audio_q;
    done_d     = 1'b0;

    // Square wave from the currently applied half period.
    if (half_q != 32'd0) begin
      if (sq_cnt_q == half_q - 32'd1) begin
        sq_cnt_d = 32'd0;
        audio_d  = ~audio_q;
      end else begin
        sq_cnt_d = sq_cnt_q + 32'd1;
      end
    end

    // One restoring-division step per cycle.
    if (div_run_q) begin
      if (rem_shift >= divisor) begin
        rem_d = 33'(rem_shift - divisor);
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = rem_shift[32:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      div_cnt_d = div_cnt_q - 6'd1;
      if (div_cnt_q == 6'd1) begin
        div_run_d  = 1'b0;
        div_done_d = 1'b1;
      end
    end

    // Finished quotient takes effect one cycle after the last step.
    if (div_done_q) begin
      half_d   = (quo_q == 32'd0) ? 32'd1 : quo_q;
      sq_cnt_d = 32'd0;
      audio_d  = 1'b0;
    end

    // Tone sample: a rest silences at once, a note (re)starts the divider,
    // discarding any division still in flight.
    if (load_q) begin
      tone_d = tone;
      if (rest_tone) begin
        div_run_d  = 1'b0;
        div_done_d = 1'b0;
        half_d     = 32'd0;
        sq_cnt_d   = 32'd0;
        audio_d    = 1'b0;
      end else begin
        div_run_d  = 1'b1;
        div_done_d = 1'b0;
        div_cnt_d  = 6'd32;
        rem_d      = {32'd0, DIVIDEND[32]};
        quo_d      = DIVIDEND[31:0];
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_PLAY;
          beat_d  = 9'd0;
          timer_d = 32'd0;
          load_d  = 1'b1;
        end
      end
      S_PLAY: begin
        if (stop || (timer_q == BEAT_LAST && beat_q == LAST_BEAT_IDX && !loop_en)) begin
          state_d    = S_IDLE;
          beat_d     = 9'd0;
          timer_d    = 32'd0;
          load_d     = 1'b0;
          div_run_d  = 1'b0;
          div_done_d = 1'b0;
          half_d     = 32'd0;
          sq_cnt_d   = 32'd0;
          audio_d    = 1'b0;
          done_d     = !stop;
        end else if (start) begin
          beat_d  = 9'd0;
          timer_d = 32'd0;
          load_d  = 1'b1;
        end else if (timer_q == BEAT_LAST) begin
          timer_d = 32'd0;
          beat_d  = (beat_q == LAST_BEAT_IDX) ? 9'd0 : beat_q + 9'd1;
          load_d  = 1'b1;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_q     <= 9'd0;
      timer_q    <= 32'd0;
      load_q     <= 1'b0;
      tone_q     <= 32'd0;
      div_run_q  <= 1'b0;
      div_cnt_q  <= 6'd0;
      rem_q      <= 33'd0;
      quo_q      <= 32'd0;
      div_done_q <= 1'b0;
      half_q     <= 32'd0;
      sq_cnt_q   <= 32'd0;
      audio_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      timer_q    <= timer_d;
      load_q     <= load_d;
      tone_q     <= tone_d;
      div_run_q  <= div_run_d;
      div_cnt_q  <= div_cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      div_done_q <= div_done_d;
      half_q     <= half_d;
      sq_cnt_q   <= sq_cnt_d;
      audio_q    <= audio_d;
      done_q     <= done_d;
    end
  end

  assign ibeatNum  = beat_q;
  assign audio     = audio_q;
  assign busy      = (state_q == S_PLAY);
  assign song_done = done_q;

endmodule

// File: tb/tb_music_player.sv
// tb/tb_music_player.sv - testbench for music_player: song-table model, tone vectors, control corner cases
module tb_music_player;

  localparam int CLK = 100000;
  localparam int BC  = 10000;
  localparam int SIL = 20000;

  logic        clk = 1'b0;
  logic        rst, start, stop, loop_en;
  logic        start2, stop2, loop2;
  logic [31:0] tone1, tone2;
  logic [8:0]  ibeat1, ibeat2;
  logic        audio1, audio2, busy1, busy2, done1, done2;

  bit          ovr_en;
  int unsigned ovr_val;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // reference model state for the main instance
  bit m_play, m_done;
  int m_k;

  always #5 clk = ~clk;

  music_player #(.CLK_HZ(100000), .BEATS_PER_SEC(10), .LAST_BEAT(3), .SILENCE_HZ(20000)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en), .tone(tone1),
    .ibeatNum(ibeat1), .audio(audio1), .busy(busy1), .song_done(done1));

  music_player #(.CLK_HZ(100000), .BEATS_PER_SEC(100), .LAST_BEAT(3), .SILENCE_HZ(200000)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2), .loop_en(loop2), .tone(tone2),
    .ibeatNum(ibeat2), .audio(audio2), .busy(busy2), .song_done(done2));

  function automatic int unsigned rom_tone(input int b);
    case (b)
      0: return 523;
      1: return 20000;
      2: return 784;
      3: return 523;
      default: return 0;
    endcase
  endfunction

  always_comb begin
    if (ovr_en) tone1 = ovr_val;
    else        tone1 = rom_tone(int'(ibeat1));
  end
  assign tone2 = ovr_val;

  function automatic int m_tone(input int m);
    return ovr_en ? int'(ovr_val) : int'(rom_tone(m % 4));
  endfunction

  // half period for a tone, 0 for a rest
  function automatic int m_half(input int t);
    int h;
    if (t == 0 || t >= SIL) return 0;
    h = CLK / (2 * t);
    return (h == 0) ? 1 : h;
  endfunction

  // Audio level k edges after the start edge: the latest note event of the
  // current or previous beat governs (rest at sample time, note 33 later).
  function automatic bit m_audio(input int k);
    int n, best_e, best_h, h, e;
    n = k / BC;
    best_e = -1;
    best_h = 0;
    for (int m = n - 1; m <= n; m++) begin
      if (m >= 0) begin
        h = m_half(m_tone(m));
        e = m * BC + 1 + ((h == 0) ? 0 : 33);
        if (e <= k && e > best_e) begin
          best_e = e;
          best_h = h;
        end
      end
    end
    if (best_e < 0 || best_h == 0) return 1'b0;
    return bit'(((k - best_e) / best_h) % 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    bit r_i, s_i, p_i, l_i;
    logic [31:0] expv;
    r_i = rst; s_i = start; p_i = stop; l_i = loop_en;
    @(posedge clk);
    #1;
    cyc++;
    if (r_i) begin
      m_play = 0; m_done = 0;
    end else if (m_play && p_i) begin
      m_play = 0; m_done = 0;
    end else if (s_i && !p_i) begin
      m_play = 1; m_k = 0; m_done = 0;
    end else if (m_play) begin
      m_k++;
      m_done = 0;
      if (m_k % (4 * BC) == 0 && !l_i) begin
        m_play = 0; m_done = 1;
      end
    end else begin
      m_done = 0;
    end
    expv = {20'd0, m_play, m_play ? 9'((m_k / BC) % 4) : 9'd0,
            m_play ? m_audio(m_k) : 1'b0, m_done};
    chk($sformatf("cyc%0d outputs{busy,beat,audio,done}", cyc),
        {20'd0, busy1, ibeat1, audio1, done1}, expv);
  endtask

  // Pulse start, then record first audio rise and following fall (edges after start).
  task automatic run_note(input bit d2, input int w, output int r, output int f);
    bit prev, a;
    r = -1; f = -1; prev = 0;
    if (d2) start2 = 1; else start = 1;
    step();
    start = 0; start2 = 0;
    for (int t = 1; t <= w; t++) begin
      step();
      a = d2 ? audio2 : audio1;
      if (a && !prev && r < 0) r = t;
      if (!a && prev && r >= 0 && f < 0) f = t;
      prev = a;
    end
  endtask

  task automatic stop_all();
    stop = 1; stop2 = 1;
    step();
    stop = 0; stop2 = 0;
    step();
  endtask

  typedef struct {
    bit d2;
    int tone;
    int exp_half;   // 0 = rest
  } vec_t;

  vec_t vecs[13];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, f, w, pulses;
    vecs[0]  = '{0, 523, 95};
    vecs[1]  = '{0, 784, 63};
    vecs[2]  = '{0, 440, 113};
    vecs[3]  = '{0, 1000, 50};
    vecs[4]  = '{0, 19999, 2};
    vecs[5]  = '{0, 200, 250};
    vecs[6]  = '{0, 20000, 0};
    vecs[7]  = '{0, 0, 0};
    vecs[8]  = '{0, 100000, 0};
    vecs[9]  = '{1, 50000, 1};
    vecs[10] = '{1, 100000, 1};
    vecs[11] = '{1, 25000, 2};
    vecs[12] = '{1, 150000, 1};

    rst = 1; start = 0; stop = 0; loop_en = 0;
    start2 = 0; stop2 = 0; loop2 = 0;
    ovr_en = 0; ovr_val = 0;
    m_play = 0; m_done = 0; m_k = 0;
    step(); step();
    rst = 0;
    chk("reset dut2", {busy2, ibeat2, audio2, done2}, 12'd0);
    step();

    // tone vectors: load latency 34 + half, then half-period spacing
    ovr_en = 1;
    for (int i = 0; i < 13; i++) begin
      ovr_val = vecs[i].tone;
      w = (vecs[i].exp_half == 0) ? 200 : 40 + 2 * vecs[i].exp_half;
      run_note(vecs[i].d2, w, r, f);
      if (vecs[i].exp_half == 0) begin
        chk($sformatf("vec%0d tone %0d rest rise", i, vecs[i].tone), r, -1);
      end else begin
        chk($sformatf("vec%0d tone %0d latency", i, vecs[i].tone), r, 34 + vecs[i].exp_half);
        chk($sformatf("vec%0d tone %0d half", i, vecs[i].tone), f - r, vecs[i].exp_half);
      end
      stop_all();
    end

    // restart during a division: the 784 Hz result must never appear
    ovr_val = 784;
    start = 1; step(); start = 0;
    repeat (10) step();
    ovr_val = 523;
    run_note(0, 230, r, f);
    chk("abort latency", r, 129);
    chk("abort half", f - r, 95);
    stop_all();
    ovr_en = 0;

    // stop 20 cycles into a division
    start = 1; step(); start = 0;
    repeat (21) step();
    stop = 1; step(); stop = 0;
    chk("stop busy/audio/done", {busy1, audio1, done1, ibeat1}, 12'd0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin step(); pulses += done1; end
    chk("stop no song_done", pulses, 0);
    run_note(0, 230, r, f);
    chk("after stop latency", r, 129);
    chk("after stop half", f - r, 95);
    stop_all();

    // stop in IDLE ignored; start+stop together acts as stop
    start = 1; stop = 1; step(); start = 0; stop = 0;
    chk("start+stop idle busy", busy1, 1'b0);

    // reset during beat 2, then start behaves as from power-up
    loop_en = 1;
    start = 1; step(); start = 0;
    repeat (2 * BC + 500) step();
    chk("beat 2 reached", ibeat1, 9'd2);
    rst = 1; step(); rst = 0;
    chk("rst outputs", {busy1, ibeat1, audio1, done1}, 12'd0);
    loop_en = 0;
    run_note(0, 230, r, f);
    chk("after rst latency", r, 129);
    chk("after rst half", f - r, 95);
    stop_all();

    // full non-looping song on the song table
    pulses = 0;
    start = 1; step(); start = 0;
    for (int i = 0; i < 4 * BC + 5; i++) begin step(); pulses += done1; end
    chk("song_done pulses", pulses, 1);
    chk("song end busy/beat/audio", {busy1, ibeat1, audio1}, 11'd0);

    // looping then ending on the short-beat instance
    ovr_val = 1000; loop2 = 1;
    start2 = 1; step(); start2 = 0;
    pulses = 0;
    for (int t = 1; t <= 8002; t++) begin
      step();
      pulses += done2;
      if (t == 3999) chk("loop beat before wrap", ibeat2, 9'd3);
      if (t == 4000) begin
        chk("loop wrap beat", ibeat2, 9'd0);
        chk("loop wrap busy", busy2, 1'b1);
        chk("loop wrap done", done2, 1'b0);
        loop2 = 0;
      end
      if (t == 8000) chk("end done/busy/beat/audio", {done2, busy2, ibeat2, audio2}, 12'h800);
      if (t == 8001) chk("end done cleared", done2, 1'b0);
    end
    chk("dut2 song_done pulses", pulses, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/music_player.md
MUSIC_PLAYER -- requirements
Module: music_player

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BEATS_PER_SEC, default 8, beat rate; beat length BEAT_CYC = CLK_HZ/BEATS_PER_SEC clocks.
REQ-003 Parameter LAST_BEAT, default 255, final beat index of the song.
REQ-004 Parameter SILENCE_HZ, default 20000; any tone >= SILENCE_HZ is a rest.
REQ-005 clk  input  1  system clock, rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle pulse; begins playback from beat 0.
REQ-008 stop  input  1  single-cycle pulse; ends playback.
REQ-009 loop_en  input  1  when 1, playback wraps from LAST_BEAT to 0 instead of ending.
REQ-010 tone  input  32  note frequency in Hz, returned combinationally by the song table for ibeatNum.
REQ-011 ibeatNum  output  9  current beat index driven to the song table.
REQ-012 audio  output  1  square-wave output to the buzzer/amplifier.
REQ-013 busy  output  1  1 while in PLAY.
REQ-014 song_done  output  1  one-cycle pulse when a non-looping song ends.

Function
REQ-015 The block SHALL have two states: IDLE and PLAY.
REQ-016 In IDLE, start SHALL enter PLAY with ibeatNum=0, beat timer=0, and a tone load of beat 0 scheduled for the next cycle.
REQ-017 In PLAY, the beat timer SHALL count 0..BEAT_CYC-1; at terminal count it SHALL return to 0 and ibeatNum SHALL increment.
REQ-018 At terminal count with ibeatNum==LAST_BEAT: if loop_en=1, ibeatNum SHALL wrap to 0 and PLAY continues; if loop_en=0, the block SHALL go to IDLE and pulse song_done for exactly one cycle.
REQ-019 stop in PLAY SHALL go to IDLE on the next edge with ibeatNum=0, audio=0, and no song_done; stop in IDLE SHALL be ignored.
REQ-020 start in PLAY SHALL restart from beat 0; start and stop asserted together SHALL act as stop.
REQ-021 One cycle after every ibeatNum change (including entry to PLAY), the block SHALL sample tone into a latch.
REQ-022 If the latched tone is 0 or >= SILENCE_HZ, the beat SHALL be a rest: audio held at 0 and no division started.
REQ-023 Otherwise, a sequential restoring divider SHALL compute half = floor(CLK_HZ / (2*tone)) over exactly 32 cycles, 1 quotient bit per cycle; results of 0 SHALL be clamped to 1.
REQ-024 While dividing, the previous note SHALL keep sounding; the new half SHALL take effect on the cycle after the divider finishes, which is 33 cycles after tone sampling.
REQ-025 On taking effect, the square counter SHALL restart at 0 with audio=0; when the counter reaches half-1, audio SHALL toggle and the counter SHALL reset to 0.
REQ-026 A beat change during a division SHALL abort the division and start a new one on the new tone; the aborted result SHALL never be applied.
REQ-027 Divider arithmetic SHALL use a 33-bit dividend (2*CLK_HZ fits) and a 32-bit quotient, with no truncation of intermediate remainders.
REQ-028 In IDLE, audio SHALL be 0 and the divider idle.

Reset
REQ-029 rst SHALL override all inputs; on the edge it is sampled: state=IDLE, ibeatNum=0, audio=0, busy=0, song_done=0, beat timer=0, square counter=0, half=0, divider idle, tone latch=0.
REQ-030 rst asserted mid-division or mid-song SHALL discard all progress; the first start after reset SHALL behave exactly as from power-up.

Verification (CLK_HZ=100000, BEATS_PER_SEC=10, LAST_BEAT=3, table model: beat0=523, beat1=20000, beat2=784, beat3=523)
REQ-031 start, loop_en=0 -> busy=1; beat 0: audio half period 95 clocks after 34-cycle load latency; ibeatNum steps every 10000 clocks.
REQ-032 Beat 1 (20000 Hz) -> audio=0 for the whole beat; beat 2 -> half period 63 clocks.
REQ-033 End of beat 3 with loop_en=0 -> song_done high for 1 cycle, busy=0, ibeatNum=0, audio=0; with loop_en=1 -> ibeatNum wraps 3->0 and busy stays 1.
REQ-034 stop 20 cycles into a division -> IDLE next cycle, audio=0, no song_done; a following start plays beat 0 at half=95.
REQ-035 rst pulse during beat 2 -> all outputs at reset values next cycle; start afterwards behaves identically to REQ-031.
REQ-036 Force tone=0 and tone=100000 -> rest (audio=0), no hang; tone=100000 with CLK_HZ=100000 -> half clamped to 1 when tone=50000 is replaced by SILENCE_HZ=200000 override.
